ps2_rx_fifo: RTL and testbench

// - System-clocked PS/2 device-to-host receiver.
// - Synchronises and filters ps2_clk/ps2_data, decodes full 11-bit frames
//   (start, 8 data LSB-first, odd parity, stop) and checks parity, start and stop bits.
// - Buffers good bytes in a FIFO with a valid/ready pop port.
// - Sits between the keyboard pins and scan-code consumers; led shows the last accepted byte.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/ps2_rx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : shared PS/2 frame constants, receiver state encoding, parity helper
// Revision 1.0
// ============================================================================
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // Parity bit that makes the total number of ones in {data, parity} odd.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~^data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// sync_fifo : single-clock first-word-fall-through FIFO, power-of-2 depth
// Revision 1.0
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// ps2_rx_fifo : PS/2 device-to-host receiver with filtered inputs and byte FIFO
// Revision 1.0
// ============================================================================
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow,
  output logic [3:0]                      led
);

  import ps2_pkg::*;

  localparam int FLT_W = $clog2(FILTER_LEN+1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES+1);

  logic [SYNC_STAGES-1:0]   clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0]   data_sync_q, data_sync_d;
  logic                     clk_s, data_s;
  logic [FLT_W-1:0]         flt_cnt_q, flt_cnt_d;
  logic                     filt_q, filt_d;
  logic                     fe_q, fe_d;
  ps2_state_e               state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d;
  logic                     par_q, par_d;
  logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
  logic                     perr_q, perr_d;
  logic                     ferr_q, ferr_d;
  logic                     ovf_q, ovf_d;
  logic [3:0]               led_q, led_d;
  logic                     push;
  logic                     fifo_full, fifo_empty;
  logic                     push_ok;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    filt_d      = filt_q;
    flt_cnt_d   = '0;
    if (clk_s != filt_q) begin
      if (flt_cnt_q == FLT_W'(FILTER_LEN-1)) begin
        filt_d = clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + FLT_W'(1);
      end
    end
    fe_d = filt_q & ~filt_d;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    to_cnt_d = to_cnt_q;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    push     = 1'b0;

    if (state_q == IDLE || fe_q) begin
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (fe_q) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d = DATA;
            idx_d   = '0;
            shift_d = '0;
          end
        end
        DATA: begin
          shift_d[idx_q] = data_s;
          if (idx_q == 3'(PS2_DATA_BITS-1)) begin
            state_d = PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A missing stop bit outranks a parity failure.
          if (!data_s) begin
            ferr_d = 1'b1;
          end else if (par_q != odd_parity(shift_q)) begin
            perr_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt_q == TO_W'(TIMEOUT_CYCLES-1)) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
    end
  end

  assign push_ok = push && (!fifo_full || (rx_ready && !fifo_empty));

  always_comb begin
    ovf_d = ovf_q | (push && !push_ok);
    led_d = push_ok ? shift_q[3:0] : led_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      flt_cnt_q   <= '0;
      filt_q      <= 1'b1;
      fe_q        <= 1'b0;
      state_q     <= IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovf_q       <= 1'b0;
      led_q       <= '0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      flt_cnt_q   <= flt_cnt_d;
      filt_q      <= filt_d;
      fe_q        <= fe_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovf_q       <= ovf_d;
      led_q       <= led_d;
    end
  end

  sync_fifo #(
    .WIDTH (PS2_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (shift_q),
    .pop     (rx_ready),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rx_valid   = !fifo_empty;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  assign led        = led_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_ps2_rx_fifo : scoreboard bench for the PS/2 receiver (shortened PS/2 timing)
// Revision 1.0
// ============================================================================
module tb_ps2_rx_fifo;

  localparam int SYNC_STAGES    = 2;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int FIFO_DEPTH     = 4;
  localparam int HALF           = 20;
  localparam int CW             = $clog2(FIFO_DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ps2_clk = 1'b1;
  logic          ps2_data = 1'b1;
  logic          rx_ready = 1'b0;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [CW-1:0] fifo_count;
  logic          parity_err, frame_err, overflow;
  logic [3:0]    led;

  int checks = 0;
  int errors = 0;
  int perr_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q [$];

  ps2_rx_fifo #(
    .SYNC_STAGES    (SYNC_STAGES),
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .led        (led)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (parity_err) perr_cnt++;
    if (frame_err)  ferr_cnt++;
  end

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic good_par,
                                           input logic stop);
    logic p;
    p = (^d) ? 1'b0 : 1'b1;
    if (!good_par) p = ~p;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic good_par, input logic stop);
    send_bits(mk_frame(d, good_par, stop), 11);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic scoreboard_pop(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (!rx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rx_valid) begin
      errors++;
      $display("FAIL %s: rx_valid never rose, expected a byte", tag);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got unexpected byte %02h, expected none", tag, rx_data);
    end else begin
      e = exp_q.pop_front();
      if (rx_data !== e) begin
        errors++;
        $display("FAIL %s: rx_data got %02h expected %02h", tag, rx_data, e);
      end
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rx_valid, rx_data, fifo_count, led, overflow, parity_err, frame_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%02h count=%0d led=%h ovf=%b perr=%b ferr=%b expected all 0",
               rx_valid, rx_data, fifo_count, led, overflow, parity_err, frame_err);
    end
  endtask

  task automatic test_basic();
    send_frame(8'h1C, 1'b1, 1'b1);
    exp_q.push_back(8'h1C);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== exp_q[0] || led !== 4'hC || fifo_count !== CW'(1)) begin
      errors++;
      $display("FAIL basic_head: valid=%b data=%02h led=%h count=%0d expected 1 1c c 1",
               rx_valid, rx_data, led, fifo_count);
    end
    scoreboard_pop("basic_pop");
    checks++;
    if (fifo_count !== CW'(0)) begin
      errors++;
      $display("FAIL basic_drain: count got %0d expected 0", fifo_count);
    end
  endtask

  task automatic test_parity();
    int p0, f0;
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_frame(8'hF0, 1'b0, 1'b1);
    checks++;
    if (perr_cnt - p0 !== 1 || ferr_cnt - f0 !== 0 || fifo_count !== CW'(0)) begin
      errors++;
      $display("FAIL parity_bad: perr_pulses=%0d ferr_pulses=%0d count=%0d expected 1 0 0",
               perr_cnt - p0, ferr_cnt - f0, fifo_count);
    end
    send_frame(8'hF0, 1'b0, 1'b0);
    checks++;
    if (perr_cnt - p0 !== 1 || ferr_cnt - f0 !== 1 || fifo_count !== CW'(0)) begin
      errors++;
      $display("FAIL both_bad: perr_pulses=%0d ferr_pulses=%0d count=%0d expected 1 1 0",
               perr_cnt - p0, ferr_cnt - f0, fifo_count);
    end
    send_frame(8'hF0, 1'b1, 1'b1);
    exp_q.push_back(8'hF0);
    scoreboard_pop("parity_good");
  endtask

  task automatic test_frame();
    int p0, f0;
    p0 = perr_cnt;
    f0 = ferr_cnt;
    send_frame(8'h5A, 1'b1, 1'b0);
    checks++;
    if (ferr_cnt - f0 !== 1 || perr_cnt - p0 !== 0 || fifo_count !== CW'(0)) begin
      errors++;
      $display("FAIL stop_bad: ferr_pulses=%0d perr_pulses=%0d count=%0d expected 1 0 0",
               ferr_cnt - f0, perr_cnt - p0, fifo_count);
    end
    send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 5);
    repeat (TIMEOUT_CYCLES - 100) @(negedge clk);
    checks++;
    if (ferr_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL timeout_early: ferr_pulses=%0d expected 1", ferr_cnt - f0);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (ferr_cnt - f0 !== 2 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: ferr_pulses=%0d valid=%b expected 2 0", ferr_cnt - f0, rx_valid);
    end
    send_frame(8'h5A, 1'b1, 1'b1);
    exp_q.push_back(8'h5A);
    scoreboard_pop("after_timeout");
  endtask

  task automatic test_overflow();
    for (int d = 1; d <= 5; d++) begin
      send_frame(8'(d), 1'b1, 1'b1);
      if (d <= FIFO_DEPTH) exp_q.push_back(8'(d));
    end
    checks++;
    if (fifo_count !== CW'(4) || overflow !== 1'b1 || led !== 4'h4) begin
      errors++;
      $display("FAIL overflow_state: count=%0d ovf=%b led=%h expected 4 1 4", fifo_count, overflow, led);
    end
    for (int i = 0; i < FIFO_DEPTH; i++) scoreboard_pop("overflow_drain");
    checks++;
    if (fifo_count !== CW'(0) || overflow !== 1'b1 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_sticky: count=%0d ovf=%b valid=%b expected 0 1 0",
               fifo_count, overflow, rx_valid);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] e;
    do_reset();
    for (int d = 8'h11; d <= 8'h14; d++) begin
      send_frame(8'(d), 1'b1, 1'b1);
      exp_q.push_back(8'(d));
    end
    checks++;
    if (fifo_count !== CW'(4) || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_fill: count=%0d ovf=%b expected 4 0", fifo_count, overflow);
    end
    // Fifth frame: pop the head exactly in the cycle the stop bit is evaluated.
    send_bits(mk_frame(8'h15, 1'b1, 1'b1), 10);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (SYNC_STAGES + FILTER_LEN) @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (rx_data !== e) begin
      errors++;
      $display("FAIL full_pop_head: rx_data got %02h expected %02h", rx_data, e);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    exp_q.push_back(8'h15);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    checks++;
    if (fifo_count !== CW'(4) || overflow !== 1'b0 || led !== 4'h5) begin
      errors++;
      $display("FAIL full_pop_push: count=%0d ovf=%b led=%h expected 4 0 5", fifo_count, overflow, led);
    end
    for (int i = 0; i < FIFO_DEPTH; i++) scoreboard_pop("full_pop_drain");
  endtask

  task automatic test_glitch_reset();
    int p0, f0;
    p0 = perr_cnt;
    f0 = ferr_cnt;
    ps2_data = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (50) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    send_frame(8'h1C, 1'b1, 1'b1);
    exp_q.push_back(8'h1C);
    scoreboard_pop("glitch_then_frame");

    send_bits(mk_frame(8'hA5, 1'b1, 1'b1), 5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== CW'(0) || rx_valid !== 1'b0 || perr_cnt != p0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL reset_midframe: count=%0d valid=%b perr_pulses=%0d ferr_pulses=%0d expected 0 0 0 0",
               fifo_count, rx_valid, perr_cnt - p0, ferr_cnt - f0);
    end
    repeat (TIMEOUT_CYCLES + 50) @(negedge clk);
    checks++;
    if (ferr_cnt != f0) begin
      errors++;
      $display("FAIL reset_idle: ferr_pulses=%0d expected 0", ferr_cnt - f0);
    end
    send_frame(8'h1C, 1'b1, 1'b1);
    exp_q.push_back(8'h1C);
    scoreboard_pop("after_reset_frame");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame();
    test_overflow();
    test_full_pop();
    test_glitch_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d bytes left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
